// File: rtl/stonyman_scan_sequencer.sv
// Stonyman frame scan sequencer.
//
// Walks a rows x cols pixel window one pixel at a time. For the first
// pixel of each row the Stonyman ROWSEL/COLSEL registers are reprogrammed
// from scratch with pulses on resp/incp/resv/incv. Each later pixel of the
// row needs a single incv pulse. After every address change the block waits
// for the settle time, then asks the ADC controller to capture. It moves on
// as soon as the ADC reports end of track, so the next address change
// overlaps the conversion.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   frame_start              start a frame scan (ignored while busy)
//   abort                    stop the scan on the next edge
//   num_rows, num_cols       window size, sampled on an accepted frame_start
//   settle_counts            settle cycles after an address change (0 acts as 1)
//   adc_capture_done         ADC controller has finished tracking the pixel
//   adc_capture_start        one-cycle capture request
//   resp/incp/resv/incv      Stonyman control pulses
//   busy, frame_done         scan status
//   cur_row, cur_col         pixel currently addressed
module stonyman_scan_sequencer #(
    parameter int PULSE_CYCLES = 2,
    parameter int MAX_DIM      = 112
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       abort,
    input  logic [6:0] num_rows,
    input  logic [6:0] num_cols,
    input  logic [7:0] settle_counts,
    input  logic       adc_capture_done,
    output logic       adc_capture_start,
    output logic       resp,
    output logic       incp,
    output logic       resv,
    output logic       incv,
    output logic       busy,
    output logic       frame_done,
    output logic [6:0] cur_row,
    output logic [6:0] cur_col
);

    localparam int PW = $clog2(2 * PULSE_CYCLES + 1);
    localparam logic [PW-1:0] PHASE_HI   = PW'(PULSE_CYCLES);
    localparam logic [PW-1:0] PHASE_LAST = PW'(2 * PULSE_CYCLES - 1);
    localparam logic [6:0]    DIM_MAX    = 7'(MAX_DIM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW_SETUP,
        S_SETTLE,
        S_CAPTURE,
        S_WAIT_DONE,
        S_COL_STEP
    } state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] phase_reg, phase_next;      // position inside one pulse (high then low)
    logic [7:0]    step_reg, step_next;        // pulse index inside ROW_SETUP
    logic [7:0]    settle_reg, settle_next;
    logic [6:0]    rows_reg, rows_next;
    logic [6:0]    cols_reg, cols_next;
    logic [6:0]    cur_row_reg, cur_row_next;
    logic [6:0]    cur_col_reg, cur_col_next;
    logic [3:0]    line_reg, line_next;        // {resp, incp, resv, incv}
    logic          start_reg, start_next;
    logic          busy_reg, busy_next;
    logic          frame_done_reg, frame_done_next;

    logic [6:0]    rows_clamped, cols_clamped;
    logic [7:0]    settle_last;
    logic [7:0]    step_last_cur, step_last_next;

    assign rows_clamped = (num_rows > DIM_MAX) ? DIM_MAX : num_rows;
    assign cols_clamped = (num_cols > DIM_MAX) ? DIM_MAX : num_cols;
    assign settle_last  = (settle_counts == 8'd0) ? 8'd0 : settle_counts - 8'd1;

    // Row programming is resp, incp, resv, incv x row, resp, resv:
    // the final pulse index is row + 4.
    assign step_last_cur  = {1'b0, cur_row_reg} + 8'd4;
    assign step_last_next = {1'b0, cur_row_next} + 8'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            phase_reg      <= '0;
            step_reg       <= '0;
            settle_reg     <= '0;
            rows_reg       <= '0;
            cols_reg       <= '0;
            cur_row_reg    <= '0;
            cur_col_reg    <= '0;
            line_reg       <= '0;
            start_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            step_reg       <= step_next;
            settle_reg     <= settle_next;
            rows_reg       <= rows_next;
            cols_reg       <= cols_next;
            cur_row_reg    <= cur_row_next;
            cur_col_reg    <= cur_col_next;
            line_reg       <= line_next;
            start_reg      <= start_next;
            busy_reg       <= busy_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        phase_next      = phase_reg;
        step_next       = step_reg;
        settle_next     = settle_reg;
        rows_next       = rows_reg;
        cols_next       = cols_reg;
        cur_row_next    = cur_row_reg;
        cur_col_next    = cur_col_reg;
        frame_done_next = 1'b0;
        line_next       = 4'b0000;

        case (state_reg)
            S_IDLE: begin
                if (frame_start && !abort) begin
                    rows_next    = rows_clamped;
                    cols_next    = cols_clamped;
                    cur_row_next = '0;
                    cur_col_next = '0;
                    phase_next   = '0;
                    step_next    = '0;
                    // An empty window completes at once without touching the sensor.
                    if (rows_clamped == 7'd0 || cols_clamped == 7'd0) begin
                        frame_done_next = 1'b1;
                    end else begin
                        state_next = S_ROW_SETUP;
                    end
                end
            end
            S_ROW_SETUP: begin
                if (phase_reg == PHASE_LAST) begin
                    phase_next = '0;
                    if (step_reg == step_last_cur) begin
                        state_next  = S_SETTLE;
                        settle_next = '0;
                    end else begin
                        step_next = step_reg + 8'd1;
                    end
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            S_SETTLE: begin
                if (settle_reg >= settle_last) begin
                    state_next = S_CAPTURE;
                end else begin
                    settle_next = settle_reg + 8'd1;
                end
            end
            S_CAPTURE: begin
                state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (adc_capture_done) begin
                    if (cur_col_reg + 7'd1 < cols_reg) begin
                        cur_col_next = cur_col_reg + 7'd1;
                        phase_next   = '0;
                        state_next   = S_COL_STEP;
                    end else if (cur_row_reg + 7'd1 < rows_reg) begin
                        cur_row_next = cur_row_reg + 7'd1;
                        cur_col_next = '0;
                        phase_next   = '0;
                        step_next    = '0;
                        state_next   = S_ROW_SETUP;
                    end else begin
                        frame_done_next = 1'b1;
                        state_next      = S_IDLE;
                    end
                end
            end
            S_COL_STEP: begin
                if (phase_reg == PHASE_LAST) begin
                    state_next  = S_SETTLE;
                    settle_next = '0;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Abort drops everything except the last addressed pixel.
        if (abort && state_reg != S_IDLE) begin
            state_next      = S_IDLE;
            frame_done_next = 1'b0;
            cur_row_next    = cur_row_reg;
            cur_col_next    = cur_col_reg;
        end

        // Outputs are decoded from the next state so they line up with it.
        if (state_next == S_ROW_SETUP && phase_next < PHASE_HI) begin
            if (step_next == 8'd0) begin
                line_next = 4'b1000;
            end else if (step_next == 8'd1) begin
                line_next = 4'b0100;
            end else if (step_next == 8'd2) begin
                line_next = 4'b0010;
            end else if (step_next == step_last_next) begin
                line_next = 4'b0010;
            end else if (step_next == step_last_next - 8'd1) begin
                line_next = 4'b1000;
            end else begin
                line_next = 4'b0001;
            end
        end else if (state_next == S_COL_STEP && phase_next < PHASE_HI) begin
            line_next = 4'b0001;
        end

        start_next = (state_next == S_CAPTURE);
        busy_next  = (state_next != S_IDLE);
    end

    assign {resp, incp, resv, incv} = line_reg;
    assign adc_capture_start        = start_reg;
    assign busy                     = busy_reg;
    assign frame_done               = frame_done_reg;
    assign cur_row                  = cur_row_reg;
    assign cur_col                  = cur_col_reg;

endmodule
